// File: rtl/led_target_sequencer.sv
// LED target sequencer: turns random indices into timed targets
// and reports hit / wrong / miss pulses to the scoring logic.
module led_target_sequencer #(
  parameter int NUM_LEDS   = 18,
  parameter int IDX_W      = 5,
  parameter int GAP_CYCLES = 25_000_000,
  parameter int ON_CYCLES  = 50_000_000,
  parameter int MAX_RETRY  = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                enable,
  input  logic [IDX_W-1:0]    random_value,
  input  logic [NUM_LEDS-1:0] hit_in,
  output logic [NUM_LEDS-1:0] leds,
  output logic [IDX_W-1:0]    target_idx,
  output logic                hit_pulse,
  output logic                wrong_pulse,
  output logic                miss_pulse,
  output logic                busy
);

  localparam int PW = IDX_W + 1;
  localparam int GW = $clog2(GAP_CYCLES) + 1;
  localparam int OW = $clog2(ON_CYCLES) + 1;
  localparam int RW = $clog2(MAX_RETRY) + 1;

  localparam logic [GW-1:0] GAP_LOAD = GW'(GAP_CYCLES - 1);
  localparam logic [OW-1:0] ON_LOAD  = OW'(ON_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MX = RW'(MAX_RETRY);
  localparam logic [PW-1:0] NUM_P    = PW'(NUM_LEDS);
  localparam logic [NUM_LEDS-1:0] ONE = NUM_LEDS'(1);

  typedef enum logic [1:0] {
    IDLE,
    GAP,
    PICK,
    SHOW
  } state_t;

  state_t state, state_n;

  logic [GW-1:0]       gap_cnt, gap_n;
  logic [OW-1:0]       on_cnt, on_n;
  logic [RW-1:0]       retry, retry_n;
  logic [PW-1:0]       prev_idx, prev_n;
  logic [PW-1:0]       fb, rv_ext;
  logic [IDX_W-1:0]    tgt_n;
  logic [NUM_LEDS-1:0] hit_q, rise, tgt_mask, leds_n;
  logic                hit_n, wrong_n, miss_n, busy_n;
  logic                done;

  assign rise     = hit_in & ~hit_q;
  assign tgt_mask = ONE << target_idx;
  assign rv_ext   = {1'b0, random_value};

  // prev_idx may hold NUM_LEDS ("none"), so wrap by subtraction
  always_comb begin
    fb = prev_idx + PW'(1);
    if (fb >= NUM_P) fb = fb - NUM_P;
  end

  always_comb begin
    state_n = state;
    gap_n   = gap_cnt;
    on_n    = on_cnt;
    retry_n = retry;
    prev_n  = prev_idx;
    tgt_n   = target_idx;
    leds_n  = '0;
    hit_n   = 1'b0;
    wrong_n = 1'b0;
    miss_n  = 1'b0;
    done    = 1'b0;
    if (!enable) begin
      state_n = IDLE;
    end else begin
      unique case (state)
        IDLE: begin
          gap_n   = GAP_LOAD;
          state_n = GAP;
        end
        GAP: begin
          if (gap_cnt == '0) begin
            retry_n = '0;
            state_n = PICK;
          end else begin
            gap_n = gap_cnt - GW'(1);
          end
        end
        PICK: begin
          if (retry == RETRY_MX) begin
            tgt_n = fb[IDX_W-1:0];
            done  = 1'b1;
          end else if (rv_ext < NUM_P && rv_ext != prev_idx) begin
            tgt_n = random_value;
            done  = 1'b1;
          end else begin
            retry_n = retry + RW'(1);
          end
          if (done) begin
            on_n    = ON_LOAD;
            leds_n  = ONE << tgt_n;
            state_n = SHOW;
          end
        end
        SHOW: begin
          leds_n = tgt_mask;
          if (|(rise & tgt_mask)) begin
            hit_n = 1'b1;
            done  = 1'b1;
          end else if (|(rise & ~tgt_mask)) begin
            wrong_n = 1'b1;
            done    = 1'b1;
          end else if (on_cnt == '0) begin
            miss_n = 1'b1;
            done   = 1'b1;
          end else begin
            on_n = on_cnt - OW'(1);
          end
          if (done) begin
            prev_n  = {1'b0, target_idx};
            gap_n   = GAP_LOAD;
            leds_n  = '0;
            state_n = GAP;
          end
        end
      endcase
    end
    busy_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gap_cnt     <= '0;
      on_cnt      <= '0;
      retry       <= '0;
      prev_idx    <= NUM_P;
      target_idx  <= '0;
      hit_q       <= '0;
      leds        <= '0;
      hit_pulse   <= 1'b0;
      wrong_pulse <= 1'b0;
      miss_pulse  <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_n;
      gap_cnt     <= gap_n;
      on_cnt      <= on_n;
      retry       <= retry_n;
      prev_idx    <= prev_n;
      target_idx  <= tgt_n;
      hit_q       <= hit_in;
      leds        <= leds_n;
      hit_pulse   <= hit_n;
      wrong_pulse <= wrong_n;
      miss_pulse  <= miss_n;
      busy        <= busy_n;
    end
  end

endmodule

// File: tb/tb_led_target_sequencer.sv
// Bench for led_target_sequencer: phase/elapsed-time model checked
// every cycle plus hand-computed literal expectations.
module tb_led_target_sequencer;

  localparam int N    = 18;
  localparam int IW   = 5;
  localparam int GAP  = 4;
  localparam int ON   = 8;
  localparam int MAXR = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable = 1'b0;
  logic [IW-1:0] random_value = '0;
  logic [N-1:0]  hit_in = '0;
  logic [N-1:0]  leds;
  logic [IW-1:0] target_idx;
  logic          hit_pulse, wrong_pulse, miss_pulse, busy;

  led_target_sequencer #(
    .NUM_LEDS(N), .IDX_W(IW), .GAP_CYCLES(GAP),
    .ON_CYCLES(ON), .MAX_RETRY(MAXR)
  ) dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .random_value(random_value), .hit_in(hit_in),
    .leds(leds), .target_idx(target_idx),
    .hit_pulse(hit_pulse), .wrong_pulse(wrong_pulse),
    .miss_pulse(miss_pulse), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_pass = 0;
  bit chk_en = 1'b0;

  // model: phase 0 idle, 1 gap, 2 pick, 3 show; m_el counts cycles in phase
  int m_ph = 0;
  int m_el = 0;
  int m_rt = 0;
  int m_tgt = 0;
  int m_prev = N;
  logic [N-1:0] one = 1;
  logic [N-1:0] hq = '0;
  logic [N-1:0] rise;
  logic [N-1:0] e_leds = '0;
  logic e_hit = 0, e_wrong = 0, e_miss = 0, e_busy = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h at %0t", nm, act, exp, $time);
  endtask

  task automatic model_step();
    int rv;
    bit acc;
    bit ev;
    if (!rst_n) begin
      m_ph = 0; m_el = 0; m_rt = 0; m_tgt = 0; m_prev = N;
      hq = '0; e_leds = '0;
      e_hit = 0; e_wrong = 0; e_miss = 0; e_busy = 0;
    end else begin
      rise = hit_in & ~hq;
      hq = hit_in;
      e_hit = 0; e_wrong = 0; e_miss = 0;
      rv = int'(random_value);
      if (!enable) begin
        m_ph = 0;
        e_leds = '0;
      end else begin
        case (m_ph)
          0: begin m_ph = 1; m_el = 0; end
          1: begin
            m_el++;
            if (m_el == GAP) begin m_ph = 2; m_rt = 0; end
          end
          2: begin
            acc = 0;
            if (m_rt == MAXR) begin
              m_tgt = (m_prev + 1) % N; acc = 1;
            end else if (rv < N && rv != m_prev) begin
              m_tgt = rv; acc = 1;
            end else m_rt++;
            if (acc) begin
              m_ph = 3; m_el = 0; e_leds = one << m_tgt;
            end
          end
          default: begin
            m_el++;
            ev = 1;
            if (rise[m_tgt]) e_hit = 1;
            else if (rise != '0) e_wrong = 1;
            else if (m_el == ON) e_miss = 1;
            else ev = 0;
            if (ev) begin
              m_prev = m_tgt; m_ph = 1; m_el = 0; e_leds = '0;
            end
          end
        endcase
      end
      e_busy = (m_ph != 0);
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rst_n);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (chk_en)
      chk("cycle",
          {5'b0, leds, target_idx, hit_pulse, wrong_pulse, miss_pulse, busy},
          {5'b0, e_leds, 5'(m_tgt), e_hit, e_wrong, e_miss, e_busy});
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk_en = 1'b1;
    tick(20);
    chk("idle_leds", 32'(leds), 32'h0);
    chk("idle_busy", 32'(busy), 32'h0);
    chk("idle_pulses", 32'({hit_pulse, wrong_pulse, miss_pulse}), 32'h0);

    random_value = 5'd5;
    enable = 1'b1;
    tick(5);
    chk("gap_dark", 32'(leds), 32'h0);
    chk("gap_busy", 32'(busy), 32'h1);
    tick(1);
    chk("show_on", 32'(leds), 32'h00020);
    chk("show_tgt", 32'(target_idx), 32'd5);
    tick(7);
    chk("lit_8th", 32'({leds, miss_pulse}), 32'({18'h00020, 1'b0}));
    tick(1);
    chk("miss", 32'({leds, miss_pulse}), 32'({18'h0, 1'b1}));
    tick(1);
    chk("miss_1cyc", 32'(miss_pulse), 32'h0);

    tick(5);
    hit_in = 18'h00080;
    tick(1);
    chk("retry_dark", 32'(leds), 32'h0);
    tick(1);
    chk("fallback_leds", 32'(leds), 32'h00040);
    chk("fallback_tgt", 32'(target_idx), 32'd6);
    tick(2);
    chk("held_no_evt", 32'({leds, hit_pulse, wrong_pulse}),
        32'({18'h00040, 2'b00}));
    hit_in = 18'h00088;
    tick(1);
    chk("wrong", 32'({leds, hit_pulse, wrong_pulse}), 32'({18'h0, 2'b01}));
    hit_in = '0;
    random_value = 5'd20;
    tick(7);
    chk("oor_dark", 32'(leds), 32'h0);
    tick(1);
    chk("oor_tgt", 32'(target_idx), 32'd7);
    chk("oor_leds", 32'(leds), 32'h00080);
    tick(1);

    #2 rst_n = 1'b0;
    #1;
    chk("rst_show", 32'({leds, target_idx, busy}), 32'h0);
    chk("rst_pulses", 32'({hit_pulse, wrong_pulse, miss_pulse}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    random_value = 5'd5;

    tick(6);
    chk("hit_show", 32'(leds), 32'h00020);
    tick(2);
    hit_in = 18'h00024;
    random_value = 5'd9;
    tick(1);
    chk("hit_prio", 32'({leds, hit_pulse, wrong_pulse, miss_pulse}),
        32'({18'h0, 3'b100}));
    tick(1);
    chk("hit_1cyc", 32'({hit_pulse, busy}), 32'h1);
    tick(3);
    chk("gap2_dark", 32'(leds), 32'h0);
    tick(1);
    chk("next_leds", 32'(leds), 32'h00200);
    chk("next_tgt", 32'(target_idx), 32'd9);
    tick(2);
    enable = 1'b0;
    hit_in = 18'h00224;
    tick(1);
    chk("abort", 32'({leds, busy, hit_pulse}), 32'h0);
    hit_in = '0;
    tick(1);
    enable = 1'b1;
    tick(1);
    chk("regap_busy", 32'(busy), 32'h1);
    tick(1);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_gap", 32'({leds, busy}), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    enable = 1'b0;
    tick(3);
    chk("post_rst_idle", 32'(busy), 32'h0);
    enable = 1'b1;
    tick(6);
    chk("restart_leds", 32'(leds), 32'h00200);
    tick(3);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
